// File: rtl/lpddr5_controller_enum.sv
// Shared LPDDR5 controller types: command encoding, bank states and default bank timings.
// Also holds the command legality rule used by every bank tracker.
package lpddr5_controller_enum;

  localparam int CMD_BITS = 3;

  // 3'b110 is deliberately left unassigned and is treated as illegal.
  typedef enum logic [CMD_BITS-1:0] {
    CMD_NOP = 3'b000,
    CMD_ACT = 3'b001,
    CMD_RD  = 3'b010,
    CMD_WR  = 3'b011,
    CMD_PRE = 3'b100,
    CMD_REF = 3'b101,
    CMD_ERR = 3'b111
  } dram_cmd_t;

  typedef enum logic [2:0] {
    BANK_IDLE        = 3'd0,
    BANK_ACTIVATING  = 3'd1,
    BANK_ACTIVE      = 3'd2,
    BANK_READING     = 3'd3,
    BANK_WRITING     = 3'd4,
    BANK_PRECHARGING = 3'd5,
    BANK_REFRESHING  = 3'd6
  } bank_state_t;

  localparam int T_RCD_DEF   = 4;
  localparam int T_RAS_DEF   = 8;
  localparam int T_RP_DEF    = 4;
  localparam int T_RFC_DEF   = 16;
  localparam int T_BURST_DEF = 4;

  // Only meaningful for the accepting states (IDLE, ACTIVE).
  function automatic logic cmd_is_legal(input bank_state_t st, input logic [CMD_BITS-1:0] c);
    logic ok;
    ok = 1'b0;
    case (c)
      CMD_NOP:                 ok = 1'b1;
      CMD_ACT, CMD_REF:        ok = (st == BANK_IDLE);
      CMD_RD, CMD_WR, CMD_PRE: ok = (st == BANK_ACTIVE);
      default:                 ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lpddr5_bank_fsm_if.sv
// Scheduler-to-bank command channel plus the bank status returned to the scheduler.
interface lpddr5_bank_fsm_if #(
  parameter int ROW_W = 16
);
  logic                                           cmd_valid;
  logic                                           cmd_ready;
  logic [lpddr5_controller_enum::CMD_BITS-1:0]    cmd;
  logic [ROW_W-1:0]                               cmd_row;
  lpddr5_controller_enum::bank_state_t            bank_state;
  logic                                           row_open;
  logic [ROW_W-1:0]                               open_row;
  logic                                           cmd_err;

  modport master (
    output cmd_valid, cmd, cmd_row,
    input  cmd_ready, bank_state, row_open, open_row, cmd_err
  );

  modport slave (
    input  cmd_valid, cmd, cmd_row,
    output cmd_ready, bank_state, row_open, open_row, cmd_err
  );
endinterface

// File: rtl/lpddr5_timer.sv
// Loadable down-counter that parks at zero; used to time the bank's transient states.
module lpddr5_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] value,
  output logic             zero
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign value = cnt_q;
  assign zero  = (cnt_q == '0);
endmodule

// File: rtl/lpddr5_bank_fsm.sv
// Per-bank LPDDR5 state tracker: accepts scheduler commands, enforces tRCD/tRAS/tRP/tRFC/burst
// timing and reports bank state and open row.
module lpddr5_bank_fsm
  import lpddr5_controller_enum::*;
#(
  parameter int ROW_W   = 16,
  parameter int CNT_W   = 8,
  parameter int T_RCD   = T_RCD_DEF,
  parameter int T_RAS   = T_RAS_DEF,
  parameter int T_RP    = T_RP_DEF,
  parameter int T_RFC   = T_RFC_DEF,
  parameter int T_BURST = T_BURST_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  lpddr5_bank_fsm_if.slave  bus
);
  // T_RAS may equal 2^CNT_W, so the tRAS count needs one extra bit.
  localparam int RAS_W = CNT_W + 1;
  localparam logic [RAS_W-1:0] RAS_MAX   = RAS_W'(T_RAS);
  localparam logic [CNT_W-1:0] LD_RCD    = CNT_W'(T_RCD - 1);
  localparam logic [CNT_W-1:0] LD_RP     = CNT_W'(T_RP - 1);
  localparam logic [CNT_W-1:0] LD_RFC    = CNT_W'(T_RFC - 1);
  localparam logic [CNT_W-1:0] LD_BURST  = CNT_W'(T_BURST - 1);

  bank_state_t      state_q, state_d;
  logic             row_open_q, row_open_d;
  logic [ROW_W-1:0] open_row_q, open_row_d;
  logic [RAS_W-1:0] ras_q, ras_d;
  logic             cmd_err_q, cmd_err_d;
  logic             cmd_ready;
  logic             accept;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_load_val;
  logic [CNT_W-1:0] tmr_value_unused;
  logic             tmr_zero;

  lpddr5_timer #(.CNT_W(CNT_W)) u_state_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .value    (tmr_value_unused),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d      = state_q;
    row_open_d   = row_open_q;
    open_row_d   = open_row_q;
    ras_d        = ras_q;
    cmd_err_d    = 1'b0;
    cmd_ready    = 1'b0;
    tmr_load     = 1'b0;
    tmr_load_val = '0;

    if ((state_q inside {BANK_ACTIVATING, BANK_ACTIVE, BANK_READING, BANK_WRITING})
        && (ras_q != RAS_MAX)) begin
      ras_d = ras_q + RAS_W'(1);
    end

    case (state_q)
      BANK_IDLE:        cmd_ready = 1'b1;
      BANK_ACTIVE:      cmd_ready = !((bus.cmd == CMD_PRE) && (ras_q != RAS_MAX));
      BANK_ACTIVATING,
      BANK_READING,
      BANK_WRITING:     if (tmr_zero) state_d = BANK_ACTIVE;
      BANK_PRECHARGING,
      BANK_REFRESHING:  if (tmr_zero) state_d = BANK_IDLE;
      default:          state_d = BANK_IDLE;
    endcase

    accept = bus.cmd_valid && cmd_ready;
    if (accept) begin
      if (!cmd_is_legal(state_q, bus.cmd)) begin
        cmd_err_d = 1'b1;
      end else begin
        case (bus.cmd)
          CMD_ACT: begin
            state_d      = BANK_ACTIVATING;
            tmr_load     = 1'b1;
            tmr_load_val = LD_RCD;
            row_open_d   = 1'b1;
            open_row_d   = bus.cmd_row;
            // The acceptance edge itself is the first elapsed tRAS cycle.
            ras_d        = RAS_W'(1);
          end
          CMD_REF: begin
            state_d      = BANK_REFRESHING;
            tmr_load     = 1'b1;
            tmr_load_val = LD_RFC;
          end
          CMD_RD: begin
            state_d      = BANK_READING;
            tmr_load     = 1'b1;
            tmr_load_val = LD_BURST;
          end
          CMD_WR: begin
            state_d      = BANK_WRITING;
            tmr_load     = 1'b1;
            tmr_load_val = LD_BURST;
          end
          CMD_PRE: begin
            state_d      = BANK_PRECHARGING;
            tmr_load     = 1'b1;
            tmr_load_val = LD_RP;
            row_open_d   = 1'b0;
            ras_d        = '0;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BANK_IDLE;
      row_open_q <= 1'b0;
      open_row_q <= '0;
      ras_q      <= '0;
      cmd_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_open_q <= row_open_d;
      open_row_q <= open_row_d;
      ras_q      <= ras_d;
      cmd_err_q  <= cmd_err_d;
    end
  end

  assign bus.cmd_ready  = cmd_ready;
  assign bus.bank_state = state_q;
  assign bus.row_open   = row_open_q;
  assign bus.open_row   = open_row_q;
  assign bus.cmd_err    = cmd_err_q;
endmodule

// File: tb/tb_lpddr5_bank_fsm.sv
// Directed bench for lpddr5_bank_fsm: stimulus queues per-cycle expectations, a monitor
// on the falling edge pops and compares them against the bank outputs.
module tb_lpddr5_bank_fsm;
  import lpddr5_controller_enum::*;

  typedef struct {
    bank_state_t st;
    logic        ro;
    logic [15:0] orow;
    logic        err;
    logic        rdy;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  string name_q[$];

  always #5 clk = ~clk;

  lpddr5_bank_fsm_if #(.ROW_W(16)) bus ();

  lpddr5_bank_fsm #(
    .ROW_W(16), .CNT_W(8), .T_RCD(4), .T_RAS(8), .T_RP(4), .T_RFC(16), .T_BURST(4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Drive inputs for the coming cycle and queue what the bank must show during it.
  task automatic step(input logic rst, input logic v, input logic [2:0] c, input logic [15:0] row,
                      input bank_state_t es, input logic ero, input logic [15:0] eor,
                      input logic eerr, input logic erdy, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n         = rst;
    bus.cmd_valid = v;
    bus.cmd       = c;
    bus.cmd_row   = row;
    e.st = es; e.ro = ero; e.orow = eor; e.err = eerr; e.rdy = erdy;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  initial begin : monitor
    exp_t  e;
    string nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        checks++;
        cyc++;
        if (bus.bank_state !== e.st || bus.row_open !== e.ro || bus.open_row !== e.orow ||
            bus.cmd_err !== e.err || bus.cmd_ready !== e.rdy) begin
          failures++;
          $display("FAIL %s #%0d: got state=%0d row_open=%0b open_row=%h err=%0b rdy=%0b, want state=%0d row_open=%0b open_row=%h err=%0b rdy=%0b",
                   nm, cyc, bus.bank_state, bus.row_open, bus.open_row, bus.cmd_err, bus.cmd_ready,
                   e.st, e.ro, e.orow, e.err, e.rdy);
        end else begin
          $display("ok   %s #%0d state=%0d row_open=%0b open_row=%h err=%0b rdy=%0b",
                   nm, cyc, bus.bank_state, bus.row_open, bus.open_row, bus.cmd_err, bus.cmd_ready);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    bus.cmd_valid = 1'b0;
    bus.cmd       = CMD_NOP;
    bus.cmd_row   = '0;

    for (int i = 0; i < 3; i++) step(0, 0, CMD_NOP, 16'h0, BANK_IDLE, 0, 16'h0, 0, 1, "reset");

    // ACT 0x1234 at edge 0, PRE presented from cycle 5, accepted at edge 8
    step(1, 1, CMD_ACT, 16'h1234, BANK_IDLE, 0, 16'h0000, 0, 1, "t1_act");
    for (int i = 1; i <= 4; i++) step(1, 0, CMD_NOP, 16'h0, BANK_ACTIVATING, 1, 16'h1234, 0, 0, "t1_activating");
    for (int i = 5; i <= 7; i++) step(1, 1, CMD_PRE, 16'h0, BANK_ACTIVE, 1, 16'h1234, 0, 0, "t1_pre_tras_wait");
    step(1, 1, CMD_PRE, 16'h0, BANK_ACTIVE, 1, 16'h1234, 0, 1, "t1_pre_accept");
    for (int i = 9; i <= 12; i++) step(1, 0, CMD_NOP, 16'h0, BANK_PRECHARGING, 0, 16'h1234, 0, 0, "t1_precharging");
    step(1, 0, CMD_NOP, 16'h0, BANK_IDLE, 0, 16'h1234, 0, 1, "t1_idle");

    // RD at edge 6, WR, illegal ACT/REF in ACTIVE, then PRE after tRAS saturation
    step(1, 1, CMD_ACT, 16'h00AB, BANK_IDLE, 0, 16'h1234, 0, 1, "t2_act");
    for (int i = 1; i <= 4; i++) step(1, 0, CMD_NOP, 16'h0, BANK_ACTIVATING, 1, 16'h00AB, 0, 0, "t2_activating");
    step(1, 0, CMD_NOP, 16'h0, BANK_ACTIVE, 1, 16'h00AB, 0, 1, "t2_active");
    step(1, 1, CMD_RD, 16'h0, BANK_ACTIVE, 1, 16'h00AB, 0, 1, "t2_rd");
    for (int i = 7; i <= 10; i++) step(1, 0, CMD_NOP, 16'h0, BANK_READING, 1, 16'h00AB, 0, 0, "t2_reading");
    step(1, 1, CMD_WR, 16'h0, BANK_ACTIVE, 1, 16'h00AB, 0, 1, "t2_wr");
    for (int i = 12; i <= 15; i++) step(1, 0, CMD_NOP, 16'h0, BANK_WRITING, 1, 16'h00AB, 0, 0, "t2_writing");
    step(1, 1, CMD_ACT, 16'hFFFF, BANK_ACTIVE, 1, 16'h00AB, 0, 1, "t2_act_illegal");
    step(1, 1, CMD_REF, 16'h0, BANK_ACTIVE, 1, 16'h00AB, 1, 1, "t2_ref_illegal");
    step(1, 1, CMD_NOP, 16'h0, BANK_ACTIVE, 1, 16'h00AB, 1, 1, "t2_nop");
    step(1, 1, CMD_PRE, 16'h0, BANK_ACTIVE, 1, 16'h00AB, 0, 1, "t2_pre");
    for (int i = 20; i <= 23; i++) step(1, 0, CMD_NOP, 16'h0, BANK_PRECHARGING, 0, 16'h00AB, 0, 0, "t2_precharging");
    step(1, 0, CMD_NOP, 16'h0, BANK_IDLE, 0, 16'h00AB, 0, 1, "t2_idle");

    // illegal commands in IDLE, each separated so every pulse is distinct
    step(1, 1, CMD_RD,  16'h0, BANK_IDLE, 0, 16'h00AB, 0, 1, "t3_rd");
    step(1, 0, CMD_NOP, 16'h0, BANK_IDLE, 0, 16'h00AB, 1, 1, "t3_rd_err");
    step(1, 1, CMD_ERR, 16'h0, BANK_IDLE, 0, 16'h00AB, 0, 1, "t3_cmderr");
    step(1, 0, CMD_NOP, 16'h0, BANK_IDLE, 0, 16'h00AB, 1, 1, "t3_cmderr_err");
    step(1, 1, 3'b110,  16'h0, BANK_IDLE, 0, 16'h00AB, 0, 1, "t3_undef");
    step(1, 0, CMD_NOP, 16'h0, BANK_IDLE, 0, 16'h00AB, 1, 1, "t3_undef_err");
    step(1, 1, CMD_PRE, 16'h0, BANK_IDLE, 0, 16'h00AB, 0, 1, "t3_pre");
    step(1, 0, CMD_NOP, 16'h0, BANK_IDLE, 0, 16'h00AB, 1, 1, "t3_pre_err");
    step(1, 0, CMD_NOP, 16'h0, BANK_IDLE, 0, 16'h00AB, 0, 1, "t3_quiet");

    // REF at edge 0 with ACT held from cycle 1
    step(1, 1, CMD_REF, 16'h0, BANK_IDLE, 0, 16'h00AB, 0, 1, "t4_ref");
    for (int i = 1; i <= 16; i++) step(1, 1, CMD_ACT, 16'h5A5A, BANK_REFRESHING, 0, 16'h00AB, 0, 0, "t4_refreshing");
    step(1, 1, CMD_ACT, 16'h5A5A, BANK_IDLE, 0, 16'h00AB, 0, 1, "t4_act_accept");
    for (int i = 18; i <= 21; i++) step(1, 0, CMD_NOP, 16'h0, BANK_ACTIVATING, 1, 16'h5A5A, 0, 0, "t4_activating");
    step(1, 1, CMD_RD, 16'h0, BANK_ACTIVE, 1, 16'h5A5A, 0, 1, "t4_rd");
    step(1, 0, CMD_NOP, 16'h0, BANK_READING, 1, 16'h5A5A, 0, 0, "t4_reading1");

    // reset dropped in the second READING cycle, checked before any further edge
    step(0, 0, CMD_NOP, 16'h0, BANK_IDLE, 0, 16'h0000, 0, 1, "t5_async_reset");
    step(0, 0, CMD_NOP, 16'h0, BANK_IDLE, 0, 16'h0000, 0, 1, "t5_reset_held");
    step(1, 1, CMD_ACT, 16'h0F0F, BANK_IDLE, 0, 16'h0000, 0, 1, "t5_act");
    for (int i = 1; i <= 4; i++) step(1, 0, CMD_NOP, 16'h0, BANK_ACTIVATING, 1, 16'h0F0F, 0, 0, "t5_activating");
    step(1, 0, CMD_NOP, 16'h0, BANK_ACTIVE, 1, 16'h0F0F, 0, 1, "t5_active");

    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
